// File: rtl/chessclk_pkg.sv
// rtl/chessclk_pkg.sv - shared state encoding and arithmetic helpers for the N-player chess clock
package chessclk_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] STOP = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] FLAG = 2'd3;

  // Widths up to 32 bits; the result saturates at 2^w-1.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  function automatic logic [31:0] onehot(input int unsigned idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/multi_player_chess_clock_if.sv
// rtl/multi_player_chess_clock_if.sv - player-button and display bus of the chess clock
interface multi_player_chess_clock_if #(
  parameter int N_PLAYERS = 2,
  parameter int TIME_W    = 16
);

  logic                          clear;
  logic [N_PLAYERS-1:0]          press;
  logic [TIME_W-1:0]             init_time;
  logic [TIME_W-1:0]             increment;
  logic [N_PLAYERS-1:0]          active;
  logic                          clr;
  logic                          waiting;
  logic [N_PLAYERS-1:0]          flag;
  logic [N_PLAYERS*TIME_W-1:0]   time_q;

  modport master (
    output clear, press, init_time, increment,
    input  active, clr, waiting, flag, time_q
  );

  modport slave (
    input  clear, press, init_time, increment,
    output active, clr, waiting, flag, time_q
  );

endinterface

// File: rtl/chessclk_prescaler.sv
// rtl/chessclk_prescaler.sv - divides the system clock down to one tick per time unit
module chessclk_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multi_player_chess_clock.sv
// rtl/multi_player_chess_clock.sv - N-player game clock: turn FSM, press edge detect and time counters
module multi_player_chess_clock
  import chessclk_pkg::*;
#(
  parameter int N_PLAYERS = 2,
  parameter int TIME_W    = 16,
  parameter int TICK_DIV  = 1000
) (
  input  logic                          clock,
  input  logic                          reset_n,
  multi_player_chess_clock_if.slave     bus
);

  localparam int IDX_W = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1;
  localparam logic [TIME_W-1:0] T_ONE = TIME_W'(1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     cur_q, cur_d;
  logic [N_PLAYERS-1:0] press_q, rise, cur_oh;
  logic [TIME_W-1:0]    times_q [N_PLAYERS];
  logic [TIME_W-1:0]    times_d [N_PLAYERS];
  logic [TIME_W-1:0]    run_t;
  logic                 tick, pre_en, pre_restart;
  int unsigned          rise_cnt, level_cnt;
  logic [IDX_W-1:0]     rise_idx, level_idx;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_PLAYERS - 1)) ? '0 : i + 1'b1;
  endfunction

  assign rise   = bus.press & ~press_q;
  assign pre_en = (state_q == RUN);

  chessclk_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (pre_en),
    .restart (pre_restart),
    .tick    (tick)
  );

  // Index decode is only meaningful when the matching count is exactly one.
  always_comb begin
    rise_cnt  = popcount(32'(rise));
    level_cnt = popcount(32'(bus.press));
    rise_idx  = '0;
    level_idx = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (rise[i])      rise_idx  = IDX_W'(i);
      if (bus.press[i]) level_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    times_d     = times_q;
    pre_restart = 1'b0;
    run_t       = times_q[cur_q] - TIME_W'(tick);
    if (bus.clear) begin
      state_d     = STOP;
      pre_restart = 1'b1;
      for (int i = 0; i < N_PLAYERS; i++) times_d[i] = bus.init_time;
    end else begin
      case (state_q)
        STOP: begin
          pre_restart = 1'b1;
          for (int i = 0; i < N_PLAYERS; i++) times_d[i] = bus.init_time;
          if (rise_cnt == 1) begin
            state_d = RUN;
            cur_d   = next_idx(rise_idx);
          end else if (rise_cnt > 1) begin
            state_d = WAIT;
          end
        end
        RUN: begin
          // An expiring tick wins over any press; a zero counter must not wrap.
          if (tick && (times_q[cur_q] <= T_ONE)) begin
            state_d        = FLAG;
            times_d[cur_q] = '0;
          end else if ((rise_cnt == 1) && (rise_idx == cur_q)) begin
            times_d[cur_q] = TIME_W'(sat_add(32'(run_t), 32'(bus.increment), TIME_W));
            cur_d          = next_idx(cur_q);
            pre_restart    = 1'b1;
          end else begin
            times_d[cur_q] = run_t;
            if (rise_cnt > 1) state_d = WAIT;
          end
        end
        WAIT: begin
          if (level_cnt == 1) begin
            state_d     = RUN;
            cur_d       = next_idx(level_idx);
            pre_restart = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= STOP;
      cur_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < N_PLAYERS; i++) times_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      press_q <= bus.press;
      times_q <= times_d;
    end
  end

  assign cur_oh      = N_PLAYERS'(onehot(32'(cur_q)));
  assign bus.active  = (state_q == RUN)  ? cur_oh : '0;
  assign bus.flag    = (state_q == FLAG) ? cur_oh : '0;
  assign bus.clr     = (state_q == STOP);
  assign bus.waiting = (state_q == WAIT);

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_pack
    assign bus.time_q[g*TIME_W +: TIME_W] = times_q[g];
  end

endmodule

// File: tb/tb_multi_player_chess_clock.sv
// tb/tb_multi_player_chess_clock.sv - directed and randomized bench for the N-player chess clock
module tb_multi_player_chess_clock;

  localparam int N  = 3;
  localparam int TW = 8;
  localparam int D  = 4;
  localparam int TMAX = (1 << TW) - 1;

  typedef logic [31:0] obs_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  multi_player_chess_clock_if #(.N_PLAYERS(N), .TIME_W(TW)) bus ();

  multi_player_chess_clock #(.N_PLAYERS(N), .TIME_W(TW), .TICK_DIV(D)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model: game phase, whose turn, time left, cycles into current time unit.
  localparam int M_STOP = 0, M_RUN = 1, M_WAIT = 2, M_FLAG = 3;
  int           m_phase;
  int           m_cur;
  int           m_pre;
  int           m_time [N];
  logic [N-1:0] m_pq;

  function automatic int ones(input logic [N-1:0] v);
    int n = 0;
    for (int i = 0; i < N; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = M_STOP;
    m_cur   = 0;
    m_pre   = 0;
    m_pq    = '0;
    for (int i = 0; i < N; i++) m_time[i] = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] r;
    int nr, t;
    bit tk;
    r  = bus.press & ~m_pq;
    nr = ones(r);
    if (bus.clear) begin
      m_phase = M_STOP;
      m_pre   = 0;
      for (int i = 0; i < N; i++) m_time[i] = int'(bus.init_time);
    end else if (m_phase == M_STOP) begin
      m_pre = 0;
      for (int i = 0; i < N; i++) m_time[i] = int'(bus.init_time);
      if (nr == 1) begin
        m_phase = M_RUN;
        m_cur   = (lowest(r) + 1) % N;
      end else if (nr >= 2) begin
        m_phase = M_WAIT;
      end
    end else if (m_phase == M_RUN) begin
      tk    = (m_pre == D - 1);
      m_pre = tk ? 0 : m_pre + 1;
      if (tk && m_time[m_cur] <= 1) begin
        m_time[m_cur] = 0;
        m_phase       = M_FLAG;
      end else begin
        t = m_time[m_cur] - (tk ? 1 : 0);
        if (nr == 1 && r[m_cur]) begin
          m_time[m_cur] = (t + int'(bus.increment) > TMAX) ? TMAX : t + int'(bus.increment);
          m_cur = (m_cur + 1) % N;
          m_pre = 0;
        end else begin
          m_time[m_cur] = t;
          if (nr >= 2) m_phase = M_WAIT;
        end
      end
    end else if (m_phase == M_WAIT) begin
      if (ones(bus.press) == 1) begin
        m_phase = M_RUN;
        m_cur   = (lowest(bus.press) + 1) % N;
        m_pre   = 0;
      end
    end
    m_pq = bus.press;
  endtask

  function automatic obs_t exp_vec();
    logic [N-1:0]    oh;
    logic [N*TW-1:0] tq;
    oh = '0;
    oh[m_cur] = 1'b1;
    for (int i = 0; i < N; i++) tq[i*TW +: TW] = TW'(m_time[i]);
    return {(m_phase == M_RUN) ? oh : 3'b000, m_phase == M_STOP, m_phase == M_WAIT,
            (m_phase == M_FLAG) ? oh : 3'b000, tq};
  endfunction

  function automatic obs_t got_vec();
    return {bus.active, bus.clr, bus.waiting, bus.flag, bus.time_q};
  endfunction

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.clear     = 1'b0;
    bus.press     = '0;
    bus.init_time = '0;
    bus.increment = '0;
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    tests++;
    if (got_vec() !== 32'h1000_0000) begin
      fails++;
      $display("FAIL reset_state got=%h exp=%h", got_vec(), 32'h1000_0000);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_handover();
    bus.init_time = 8'd5;
    bus.increment = 8'd0;
    bus.press     = '0;
    cycle();
    tests++;
    if (bus.time_q !== 24'h050505) begin
      fails++;
      $display("FAIL stop_load got=%h exp=%h", bus.time_q, 24'h050505);
    end
    bus.press = 3'b001;
    cycle();
    tests++;
    if (bus.active !== 3'b010 || bus.clr !== 1'b0) begin
      fails++;
      $display("FAIL handover_active got=%b/%b exp=010/0", bus.active, bus.clr);
    end
    bus.press = '0;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      tests++;
      if (bus.time_q[15:8] !== ((k < 4) ? 8'd5 : 8'd4) || got_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL handover_decrement k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_increment();
    for (int k = 0; k < 4; k++) cycle();
    tests++;
    if (bus.time_q[15:8] !== 8'd3) begin
      fails++;
      $display("FAIL increment_setup got=%0d exp=3", bus.time_q[15:8]);
    end
    bus.increment = 8'd2;
    bus.press     = 3'b010;
    cycle();
    tests++;
    if (bus.time_q[15:8] !== 8'd5 || bus.active !== 3'b100) begin
      fails++;
      $display("FAIL increment_apply got=%0d/%b exp=5/100", bus.time_q[15:8], bus.active);
    end
    bus.press = '0;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      tests++;
      if (bus.time_q[23:16] !== ((k < 4) ? 8'd5 : 8'd4) || got_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL increment_restart k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [N*TW-1:0] snap;
    bus.press = 3'b101;
    cycle();
    snap = bus.time_q;
    tests++;
    if (bus.waiting !== 1'b1 || bus.active !== 3'b000 || got_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL wait_enter got=%h exp=%h", got_vec(), exp_vec());
    end
    for (int k = 0; k < 3; k++) begin
      cycle();
      tests++;
      if (bus.time_q !== snap || bus.waiting !== 1'b1) begin
        fails++;
        $display("FAIL wait_freeze got=%h/%b exp=%h/1", bus.time_q, bus.waiting, snap);
      end
    end
    bus.press = 3'b100;
    cycle();
    tests++;
    if (bus.active !== 3'b001 || bus.waiting !== 1'b0) begin
      fails++;
      $display("FAIL wait_exit got=%b/%b exp=001/0", bus.active, bus.waiting);
    end
  endtask

  task automatic test_flag();
    obs_t snap;
    bus.clear = 1'b1;
    cycle();
    bus.clear     = 1'b0;
    bus.init_time = 8'd1;
    bus.press     = '0;
    cycle();
    bus.press = 3'b010;
    cycle();
    bus.press = '0;
    for (int k = 0; k < 3; k++) cycle();
    bus.press = 3'b100;
    cycle();
    tests++;
    if (bus.flag !== 3'b100 || bus.time_q[23:16] !== 8'd0 || bus.active !== 3'b000) begin
      fails++;
      $display("FAIL flag_fall got=%b/%0d/%b exp=100/0/000", bus.flag, bus.time_q[23:16], bus.active);
    end
    snap = got_vec();
    for (int k = 0; k < 6; k++) begin
      bus.press = 3'($urandom);
      cycle();
      tests++;
      if (got_vec() !== snap || got_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL flag_hold got=%h exp=%h", got_vec(), snap);
      end
    end
  endtask

  task automatic test_saturation_clear();
    bus.clear     = 1'b1;
    bus.init_time = 8'd250;
    bus.increment = 8'd10;
    cycle();
    bus.clear = 1'b0;
    bus.press = '0;
    cycle();
    bus.press = 3'b001;
    cycle();
    bus.press = '0;
    cycle();
    bus.press = 3'b010;
    cycle();
    tests++;
    if (bus.time_q[15:8] !== 8'd255 || got_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL saturation got=%0d exp=255", bus.time_q[15:8]);
    end
    bus.clear     = 1'b1;
    bus.init_time = 8'd0;
    cycle();
    bus.clear = 1'b0;
    bus.press = '0;
    cycle();
    bus.press = 3'b001;
    cycle();
    bus.press = '0;
    for (int k = 0; k < 4; k++) cycle();
    tests++;
    if (bus.flag !== 3'b010 || bus.time_q[15:8] !== 8'd0) begin
      fails++;
      $display("FAIL zero_start got=%b/%0d exp=010/0", bus.flag, bus.time_q[15:8]);
    end
    bus.init_time = 8'd7;
    bus.clear     = 1'b1;
    cycle();
    bus.clear = 1'b0;
    tests++;
    if (bus.clr !== 1'b1 || bus.time_q !== 24'h070707) begin
      fails++;
      $display("FAIL clear_from_flag got=%b/%h exp=1/070707", bus.clr, bus.time_q);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      bus.press     = ($urandom_range(0, 9) < 6) ? 3'b000 : 3'($urandom);
      bus.clear     = ($urandom_range(0, 59) == 0);
      bus.init_time = 8'($urandom_range(0, 6));
      bus.increment = ($urandom_range(0, 19) == 0) ? 8'd250 : 8'($urandom_range(0, 3));
      cycle();
      tests++;
      if (got_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL random k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
      end
    end
    bus.clear = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.clear     = 1'b1;
    bus.init_time = 8'd9;
    cycle();
    bus.clear = 1'b0;
    bus.press = '0;
    cycle();
    bus.press = 3'b001;
    cycle();
    bus.press = '0;
    cycle();
    tests++;
    if (bus.active !== 3'b010) begin
      fails++;
      $display("FAIL async_setup got=%b exp=010", bus.active);
    end
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    tests++;
    if (got_vec() !== 32'h1000_0000) begin
      fails++;
      $display("FAIL async_reset got=%h exp=%h", got_vec(), 32'h1000_0000);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    cycle();
    tests++;
    if (got_vec() !== exp_vec() || bus.time_q !== 24'h090909) begin
      fails++;
      $display("FAIL after_reset got=%h exp=%h", got_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_handover();
    test_increment();
    test_simultaneous();
    test_flag();
    test_saturation_clear();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_player_chess_clock.md
# multi_player_chess_clock

Parametrised N-player game clock: tracks remaining time per player, passes the turn round-robin on button presses, applies a per-move time increment and flags the first player to run out. Generalised successor of the two-player chess clock FSM with Stop/Run/Wait behaviour and per-player time counters. Sits between debounced player-button inputs and the display/annunciator logic.

## Interface
- N_PLAYERS, 2: number of players; must be at least 2. The index width is IDX_W = max(1, clog2(N_PLAYERS)).
- TIME_W, 16: width of each per-player time counter, in time units.
- TICK_DIV, 1000: clock cycles per time unit; must be at least 1.

- clock, in, 1: single system clock. All logic is rising-edge.
- reset_n, in, 1: asynchronous, active-low reset.
- clear, in, 1: synchronous return to STOP from any state.
- press, in, N_PLAYERS: per-player button levels, already debounced and synchronous to clock.
- init_time, in, TIME_W: starting time, loaded into every counter while in STOP.
- increment, in, TIME_W: time added to the moving player on each hand-over. 0 disables the increment.
- active, out, N_PLAYERS: one-hot; the bit for the running player is high in RUN only.
- clr, out, 1: high while in STOP.
- waiting, out, 1: high while in WAIT.
- flag, out, N_PLAYERS: one-hot; marks the expired player while in FLAG.
- time_q, out, N_PLAYERS*TIME_W: packed remaining times; player i is bits [i*TIME_W +: TIME_W].

## Operation
- States: STOP, RUN, WAIT, FLAG.
- Reset state and outputs:
  - State is STOP; cur = 0; prescaler = 0.
  - All counters are 0; press_q = 0.
  - active = 0, flag = 0, waiting = 0, clr = 1.
- Press edges: rise = press & ~press_q. press_q is registered every cycle in every state.
- Successor: next(i) = (i+1) mod N_PLAYERS.
- Priority: clear beats every other event. clear goes to STOP from any state, including FLAG and WAIT.
- STOP:
  - Every cycle, all counters load init_time and the prescaler is 0.
  - Exactly one bit i of rise set: go to RUN with cur = next(i).
  - Two or more bits of rise set: go to WAIT.
  - No rise: remain in STOP.
- RUN:
  - The prescaler counts 0..TICK_DIV-1. tick is asserted when the prescaler equals TICK_DIV-1.
  - On tick, time[cur] decrements by 1.
  - If the decrement reaches 0: go to FLAG with flag = onehot(cur). Any press in the same cycle is ignored.
  - Otherwise, exactly one bit of rise set, equal to cur:
    - time[cur] becomes sat(time[cur] - tick + increment), saturating at 2^TIME_W-1.
    - cur becomes next(cur); prescaler becomes 0.
  - Exactly one bit of rise set, not equal to cur: ignored.
  - Two or more bits of rise set: go to WAIT. Counters freeze; cur is kept.
- WAIT:
  - Counters and the prescaler hold.
  - While the number of set bits of the press level is not 1, remain in WAIT.
  - When exactly one level bit i is set: go to RUN with cur = next(i) and prescaler = 0. No increment is applied.
- FLAG:
  - Counters, cur and flag all hold.
  - Only clear or reset exits FLAG.
- Zero start: if init_time is 0, the first STOP→RUN transition goes to FLAG on the first tick.
  - The decrement wraps to all-ones internally but is not committed. The flagged counter reads 0.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- Latency from a press rising edge to the active change is one clock: press is sampled at edge k and active updates after edge k.
- With TICK_DIV = D, the running counter decrements once every D cycles, starting D cycles after it becomes active.
- The prescaler restarts on every hand-over, so each turn starts on a full time unit.
- Saturation: if sum ≥ 2^TIME_W, the counter holds all-ones.
- reset_n asserted mid-operation clears all state immediately (asynchronously). Release is to be synchronised by the reset tree upstream.

## Structure
- Shared package chessclk_pkg holds:
  - the state encoding: STOP=2'd0, RUN=2'd1, WAIT=2'd2, FLAG=2'd3;
  - a saturating-add function;
  - a one-hot/popcount helper.
- Sub-module chessclk_prescaler (parameter TICK_DIV):
  - inputs: clock, reset_n, en, restart;
  - output: tick.
- The counter array, the edge detector and the FSM live in the top module.

## Test plan
- Use N_PLAYERS=3, TIME_W=8, TICK_DIV=4 throughout.
- Reset then hand-over: init_time=5, increment=0.
  - Stimulus: pulse press[0].
  - Response: clr drops, active=3'b010 one cycle later; time1 decrements every 4 cycles.
- Increment on hand-over: time1=3 with increment=2.
  - Stimulus: press[1] rises with no tick.
  - Response: time1=5, active=3'b100, prescaler restarts.
- Simultaneous presses:
  - Stimulus: press rises on bits 0 and 2 together in RUN.
  - Response: waiting=1, counters frozen. Releasing to press=3'b100 gives RUN with active=3'b001.
- Flag fall:
  - Stimulus: time2=1 at a tick, with press[2] rising in the same cycle.
  - Response: flag=3'b100, time2=0, active=0, the press is ignored. Further presses change nothing.
- Saturation and clear:
  - Stimulus: time=250 with increment=10 on hand-over.
  - Response: counter reads 255.
  - Stimulus: clear asserted in FLAG.
  - Response: clr=1 and every counter equals init_time the next cycle.
- Asynchronous reset:
  - Stimulus: reset_n asserted mid-RUN.
  - Response: all outputs reach their reset values without waiting for a clock edge.
